// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline sequencer: sequencer states, register-write
// sources and the saturating event counter helper.
package pipeline_sequencer_pkg;

   typedef enum logic [1:0] {
      StRun,
      StMemWait,
      StRedirect
   } seq_state_t;

   typedef enum logic [1:0] {
      REG_WRITE_FROM_ALU,
      REG_WRITE_FROM_MEM,
      REG_WRITE_FROM_PC
   } reg_write_src_t;

   localparam int unsigned CountWidth = 16;
   localparam logic [CountWidth-1:0] CountMax = 16'hFFFF;

   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] c);
      return (c == CountMax) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard detection between the decode-stage sources and a load
// sitting in the compute stage.
module hazard_detect (
   input  logic       valid_decode_i,
   input  logic       valid_compute_i,
   input  logic       x_rd_enable_i,
   input  logic [4:0] x_rd_i,
   input  logic       x_rd_from_mem_i,
   input  logic [4:0] d_rs1_i,
   input  logic [4:0] d_rs2_i,
   input  logic       d_rs1_used_i,
   input  logic       d_rs2_used_i,
   output logic       hazard_o
);

   logic rs_match;

   always_comb begin
      rs_match = (d_rs1_used_i && (d_rs1_i == x_rd_i)) ||
                 (d_rs2_used_i && (d_rs2_i == x_rd_i));
      // x0 is hardwired, so a load targeting it never produces a dependency.
      hazard_o = valid_decode_i && valid_compute_i && x_rd_enable_i && x_rd_from_mem_i &&
                 (x_rd_i != 5'd0) && rs_match;
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: per-stage enables, valid tracking, memory
// freeze, jump redirect/flush and load-use stall, with saturating counters.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic        dmem_busy,
   input  logic [4:0]  d_rs1,
   input  logic [4:0]  d_rs2,
   input  logic        d_rs1_used,
   input  logic        d_rs2_used,
   input  logic        x_rd_enable,
   input  logic [4:0]  x_rd,
   input  logic        x_rd_from_mem,
   input  logic        x_jump_enable,
   output logic        en_fetch,
   output logic        en_decode,
   output logic        en_compute,
   output logic        en_mem,
   output logic        en_wb,
   output logic        valid_decode,
   output logic        valid_compute,
   output logic        valid_mem,
   output logic        valid_wb,
   output logic        pc_redirect,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   seq_state_t  state_q, state_d;
   logic        squash_q, squash_d;
   logic        valid_decode_q, valid_decode_d;
   logic        valid_compute_q, valid_compute_d;
   logic        valid_mem_q, valid_mem_d;
   logic        valid_wb_q, valid_wb_d;
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;
   logic        hazard, freeze, jump;

   hazard_detect u_hazard_detect (
      .valid_decode_i  (valid_decode_q),
      .valid_compute_i (valid_compute_q),
      .x_rd_enable_i   (x_rd_enable),
      .x_rd_i          (x_rd),
      .x_rd_from_mem_i (x_rd_from_mem),
      .d_rs1_i         (d_rs1),
      .d_rs2_i         (d_rs2),
      .d_rs1_used_i    (d_rs1_used),
      .d_rs2_used_i    (d_rs2_used),
      .hazard_o        (hazard)
   );

   assign freeze = valid_mem_q && dmem_busy;
   assign jump   = valid_compute_q && x_jump_enable && !freeze;

   always_comb begin
      state_d         = StRun;
      squash_d        = squash_q;
      valid_decode_d  = valid_decode_q;
      valid_compute_d = valid_compute_q;
      valid_mem_d     = valid_mem_q;
      valid_wb_d      = valid_wb_q;
      stall_d         = stall_q;
      flush_d         = flush_q;
      en_fetch        = 1'b1;
      en_decode       = 1'b1;
      en_compute      = 1'b1;
      en_mem          = 1'b1;
      en_wb           = 1'b1;
      pc_redirect     = 1'b0;

      if (reset) begin
         // Enables stay high so every stage register sees its own reset.
         squash_d        = 1'b0;
         valid_decode_d  = 1'b0;
         valid_compute_d = 1'b0;
         valid_mem_d     = 1'b0;
         valid_wb_d      = 1'b0;
         stall_d         = '0;
         flush_d         = '0;
      end else if (freeze) begin
         en_fetch   = 1'b0;
         en_decode  = 1'b0;
         en_compute = 1'b0;
         en_mem     = 1'b0;
         en_wb      = 1'b0;
         state_d    = StMemWait;
         stall_d    = sat_inc(stall_q);
      end else if (jump) begin
         pc_redirect     = 1'b1;
         valid_decode_d  = 1'b0;
         valid_compute_d = 1'b0;
         valid_mem_d     = valid_compute_q;
         valid_wb_d      = valid_mem_q;
         squash_d        = 1'b1;
         state_d         = StRedirect;
         flush_d         = sat_inc(flush_q);
      end else if (hazard) begin
         en_fetch        = 1'b0;
         en_decode       = 1'b0;
         valid_compute_d = 1'b0;
         valid_mem_d     = valid_compute_q;
         valid_wb_d      = valid_mem_q;
         stall_d         = sat_inc(stall_q);
      end else begin
         // The squash survives a freeze so the wrong-path fetch is still dropped.
         en_fetch        = imem_valid;
         valid_decode_d  = squash_q ? 1'b0 : imem_valid;
         valid_compute_d = valid_decode_q;
         valid_mem_d     = valid_compute_q;
         valid_wb_d      = valid_mem_q;
         squash_d        = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      state_q         <= state_d;
      squash_q        <= squash_d;
      valid_decode_q  <= valid_decode_d;
      valid_compute_q <= valid_compute_d;
      valid_mem_q     <= valid_mem_d;
      valid_wb_q      <= valid_wb_d;
      stall_q         <= stall_d;
      flush_q         <= flush_d;
   end

   assign valid_decode  = valid_decode_q;
   assign valid_compute = valid_compute_q;
   assign valid_mem     = valid_mem_q;
   assign valid_wb      = valid_wb_q;
   assign stall_count   = stall_q;
   assign flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a combinational enable table from a
// full pipeline, then multi-cycle stall, freeze, jump, saturation and reset sequences.
module tb_pipeline_sequencer;
   import pipeline_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_valid, dmem_busy;
   logic [4:0]  d_rs1, d_rs2, x_rd;
   logic        d_rs1_used, d_rs2_used, x_rd_enable, x_rd_from_mem, x_jump_enable;
   logic        en_fetch, en_decode, en_compute, en_mem, en_wb;
   logic        valid_decode, valid_compute, valid_mem, valid_wb, pc_redirect;
   logic [15:0] stall_count, flush_count;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   pipeline_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .imem_valid    (imem_valid),
      .dmem_busy     (dmem_busy),
      .d_rs1         (d_rs1),
      .d_rs2         (d_rs2),
      .d_rs1_used    (d_rs1_used),
      .d_rs2_used    (d_rs2_used),
      .x_rd_enable   (x_rd_enable),
      .x_rd          (x_rd),
      .x_rd_from_mem (x_rd_from_mem),
      .x_jump_enable (x_jump_enable),
      .en_fetch      (en_fetch),
      .en_decode     (en_decode),
      .en_compute    (en_compute),
      .en_mem        (en_mem),
      .en_wb         (en_wb),
      .valid_decode  (valid_decode),
      .valid_compute (valid_compute),
      .valid_mem     (valid_mem),
      .valid_wb      (valid_wb),
      .pc_redirect   (pc_redirect),
      .stall_count   (stall_count),
      .flush_count   (flush_count)
   );

   typedef struct {
      logic       imem;
      logic       busy;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       rde;
      logic [4:0] rd;
      logic       fm;
      logic       jmp;
      logic [4:0] exp_en;
      logic       exp_pr;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [4:0] en_vec();
      return {en_fetch, en_decode, en_compute, en_mem, en_wb};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      imem_valid    = 1'b0;
      dmem_busy     = 1'b0;
      d_rs1         = 5'd0;
      d_rs2         = 5'd0;
      d_rs1_used    = 1'b0;
      d_rs2_used    = 1'b0;
      x_rd_enable   = 1'b0;
      x_rd          = 5'd0;
      x_rd_from_mem = 1'b0;
      x_jump_enable = 1'b0;
   endtask

   // Reset, then fetch four instructions so every stage holds a valid one.
   task automatic reset_prime();
      reset = 1'b1;
      clear_inputs();
      step();
      reset = 1'b0;
      imem_valid = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'b11111, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b01111, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00000, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11111, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b00000, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'b00111, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'b00111, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'b11111, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'b11111, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11111, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'b11111, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'b11111, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'b00000, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'b11111, 1'b0};

      // Reset state and reset-time outputs.
      clear_inputs();
      reset = 1'b1;
      x_jump_enable = 1'b1;
      #1;
      check("reset_en", 32'(en_vec()), 32'h1f);
      check("reset_pc_redirect", 32'(pc_redirect), 32'h0);
      step();
      check("reset_valids", 32'({valid_decode, valid_compute, valid_mem, valid_wb}), 32'h0);
      check("reset_stall", 32'(stall_count), 32'h0);
      check("reset_flush", 32'(flush_count), 32'h0);
      check("reset_state", 32'(dut.state_q), 32'(StRun));

      // Combinational enable table from a full pipeline.
      reset_prime();
      check("prime_valids", 32'({valid_decode, valid_compute, valid_mem, valid_wb}), 32'hf);
      for (int i = 0; i < 14; i++) begin
         imem_valid    = vecs[i].imem;
         dmem_busy     = vecs[i].busy;
         d_rs1         = vecs[i].rs1;
         d_rs2         = vecs[i].rs2;
         d_rs1_used    = vecs[i].u1;
         d_rs2_used    = vecs[i].u2;
         x_rd_enable   = vecs[i].rde;
         x_rd          = vecs[i].rd;
         x_rd_from_mem = vecs[i].fm;
         x_jump_enable = vecs[i].jmp;
         #1;
         check($sformatf("vec%0d_en", i), 32'(en_vec()), 32'(vecs[i].exp_en));
         check($sformatf("vec%0d_pc_redirect", i), 32'(pc_redirect), 32'(vecs[i].exp_pr));
      end

      // Load x5 then use x5: one stall cycle.
      reset_prime();
      x_rd_enable = 1'b1; x_rd = 5'd5; x_rd_from_mem = 1'b1;
      d_rs1 = 5'd5; d_rs1_used = 1'b1;
      #1;
      check("lu_en_decode", 32'(en_decode), 32'h0);
      step();
      check("lu_valid_compute", 32'(valid_compute), 32'h0);
      check("lu_valid_decode_held", 32'(valid_decode), 32'h1);
      check("lu_stall", 32'(stall_count), 32'h1);
      check("lu_en_decode_after", 32'(en_decode), 32'h1);
      step();
      check("lu_stall_once", 32'(stall_count), 32'h1);

      // Load to x0 then use x0: no stall.
      reset_prime();
      x_rd_enable = 1'b1; x_rd = 5'd0; x_rd_from_mem = 1'b1;
      d_rs1 = 5'd0; d_rs1_used = 1'b1;
      #1;
      check("x0_en_decode", 32'(en_decode), 32'h1);
      step();
      check("x0_stall", 32'(stall_count), 32'h0);
      check("x0_valid_compute", 32'(valid_compute), 32'h1);

      // Memory busy for three cycles.
      reset_prime();
      dmem_busy = 1'b1; imem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("freeze%0d_en", i), 32'(en_vec()), 32'h0);
         step();
         check($sformatf("freeze%0d_state", i), 32'(dut.state_q), 32'(StMemWait));
      end
      check("freeze_stall", 32'(stall_count), 32'h3);
      check("freeze_valids_held", 32'({valid_decode, valid_compute, valid_mem, valid_wb}), 32'hf);
      dmem_busy = 1'b0;
      #1;
      check("freeze_exit_en", 32'(en_vec()), 32'h0f);
      step();
      check("freeze_exit_state", 32'(dut.state_q), 32'(StRun));
      check("freeze_exit_valid_decode", 32'(valid_decode), 32'h0);
      check("freeze_exit_stall", 32'(stall_count), 32'h3);

      // Jump together with a load-use hazard.
      reset_prime();
      x_jump_enable = 1'b1;
      x_rd_enable = 1'b1; x_rd = 5'd5; x_rd_from_mem = 1'b1;
      d_rs1 = 5'd5; d_rs1_used = 1'b1;
      #1;
      check("jump_pc_redirect", 32'(pc_redirect), 32'h1);
      check("jump_en", 32'(en_vec()), 32'h1f);
      step();
      check("jump_vd_c1", 32'(valid_decode), 32'h0);
      check("jump_vc_c1", 32'(valid_compute), 32'h0);
      check("jump_vm_c1", 32'(valid_mem), 32'h1);
      check("jump_state", 32'(dut.state_q), 32'(StRedirect));
      check("jump_flush", 32'(flush_count), 32'h1);
      check("jump_no_stall", 32'(stall_count), 32'h0);
      clear_inputs();
      imem_valid = 1'b1;
      #1;
      check("redirect_pc_redirect", 32'(pc_redirect), 32'h0);
      step();
      check("jump_vd_c2", 32'(valid_decode), 32'h0);
      check("redirect_exit_state", 32'(dut.state_q), 32'(StRun));
      step();
      check("jump_vd_c3", 32'(valid_decode), 32'h1);

      // Reset asserted in the redirect cycle.
      reset_prime();
      x_jump_enable = 1'b1;
      step();
      check("rr_state", 32'(dut.state_q), 32'(StRedirect));
      reset = 1'b1;
      clear_inputs();
      step();
      check("rr_state_after", 32'(dut.state_q), 32'(StRun));
      check("rr_valids", 32'({valid_decode, valid_compute, valid_mem, valid_wb}), 32'h0);
      check("rr_flush", 32'(flush_count), 32'h0);

      // Stall counter saturation, then reset mid-MEM_WAIT.
      reset_prime();
      dmem_busy = 1'b1;
      repeat (70000) step();
      check("sat_stall", 32'(stall_count), 32'hffff);
      check("sat_state", 32'(dut.state_q), 32'(StMemWait));
      reset = 1'b1;
      step();
      check("mw_reset_state", 32'(dut.state_q), 32'(StRun));
      check("mw_reset_valids", 32'({valid_decode, valid_compute, valid_mem, valid_wb}), 32'h0);
      check("mw_reset_stall", 32'(stall_count), 32'h0);
      check("mw_reset_flush", 32'(flush_count), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have ports: clock in 1 (system clock); reset in 1 (synchronous, active-high).
REQ-002 SHALL have port imem_valid in 1: the fetched instruction is available this cycle.
REQ-003 SHALL have port dmem_busy in 1: the memory stage needs at least one more cycle.
REQ-004 SHALL have ports d_rs1, d_rs2 in 5 each, and d_rs1_used, d_rs2_used in 1 each: source registers of the decode-stage instruction.
REQ-005 SHALL have ports x_rd_enable in 1, x_rd in 5, x_rd_from_mem in 1 (source==REG_WRITE_FROM_MEM) and x_jump_enable in 1: the compute-stage registered outputs.
REQ-006 SHALL have outputs en_fetch, en_decode, en_compute, en_mem, en_wb, each 1: per-stage register enables.
REQ-007 SHALL have outputs valid_decode, valid_compute, valid_mem, valid_wb, each 1: the stage holds a real instruction.
REQ-008 SHALL have outputs pc_redirect 1 (fetch loads the jump target) and stall_count, flush_count, each 16.

Function
REQ-009 SHALL implement states RUN, MEM_WAIT and REDIRECT, held in a registered state variable.
REQ-010 Freeze condition: valid_mem & dmem_busy; this SHALL take highest priority after reset.
REQ-011 During a freeze, all en_* SHALL be 0, valid bits SHALL hold, state SHALL be MEM_WAIT, and stall_count SHALL increment.
REQ-012 MEM_WAIT SHALL exit to RUN in the first cycle dmem_busy=0, and the pipeline SHALL advance in that same cycle.
REQ-013 Jump condition: valid_compute & x_jump_enable & no freeze. It SHALL assert pc_redirect combinationally and all en_*=1.
REQ-014 On a jump, valid_decode SHALL clear and valid_compute SHALL clear (bubble) next cycle; the state SHALL enter REDIRECT for exactly 1 cycle; flush_count SHALL increment.
REQ-015 In REDIRECT, valid_decode SHALL load 0 regardless of imem_valid (squash the wrong-path fetch); the state SHALL then return to RUN.
REQ-016 Load-use hazard: valid_decode & valid_compute & x_rd_enable & x_rd_from_mem & x_rd!=0 & ((d_rs1_used & d_rs1==x_rd) | (d_rs2_used & d_rs2==x_rd)).
REQ-017 On a hazard without freeze or jump: en_fetch=en_decode=0; en_compute, en_mem and en_wb SHALL be 1; valid_compute SHALL load 0; stall_count SHALL increment.
REQ-018 Jump SHALL take priority over hazard in the same cycle.
REQ-019 When the pipeline advances: valid_mem<=valid_compute, valid_wb<=valid_mem, valid_compute<=valid_decode (unless squashed), valid_decode<=imem_valid.
REQ-020 When imem_valid=0 in RUN: en_fetch SHALL be 0 and a bubble SHALL enter decode.
REQ-021 Counters SHALL saturate at 16'hFFFF, with no wrap.
REQ-022 The only combinational paths SHALL be from inputs to en_* and pc_redirect; valid_* and the counters SHALL be registered outputs.

Reset
REQ-023 While reset=1, all valid_* SHALL be 0, state SHALL be RUN, and both counters SHALL be 0.
REQ-024 While reset=1, en_* SHALL be 1 so downstream stages apply their own reset, and pc_redirect SHALL be 0.
REQ-025 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abandon the state within 1 cycle.

Structure
REQ-026 State enum seq_state_t and the REG_WRITE_FROM_MEM comparison SHALL reuse or extend the shared isa_types package.
REQ-027 One sub-module, hazard_detect (pure combinational implementation of REQ-016), is natural; everything else SHALL stay flat.

Verification
REQ-028 Load x5 followed by add using rs1=x5 -> exactly one cycle with en_decode=0 and valid_compute=0 next; stall_count=1.
REQ-029 Load with x_rd=0 followed by a use of x0 -> no stall; stall_count=0.
REQ-030 dmem_busy high 3 cycles with valid_mem=1 -> en_* all 0 for 3 cycles, state MEM_WAIT, stall_count=3, advance on the 4th cycle.
REQ-031 Jump with a simultaneous hazard -> pc_redirect=1, no hazard stall, valid_decode 0 for 2 cycles, flush_count=1.
REQ-032 Force 70000 hazard cycles -> stall_count holds 16'hFFFF; asserting reset mid-MEM_WAIT -> next cycle state RUN, valid_*=0, counters 0.
